// File: rtl/glove_region_detector_pkg.sv
// Shared constants, FSM encoding and band lookup for the glove region detector.
package glove_region_detector_pkg;

    localparam int H_ACTIVE  = 640;
    localparam int V_ACTIVE  = 480;
    localparam int REGION_W  = 160;
    localparam int NUM_BANDS = 4;

    localparam int BAND_RED    = 0;
    localparam int BAND_GREEN  = 1;
    localparam int BAND_BLUE   = 2;
    localparam int BAND_YELLOW = 3;

    localparam logic [7:0] R_MIN   = 8'd150;
    localparam logic [7:0] RG_DIFF = 8'd60;
    localparam logic [7:0] RB_DIFF = 8'd60;

    localparam int PIX_THRESH = 2000;
    localparam int DEB_FRAMES = 3;
    localparam int DEB_W      = 4;
    localparam int CNT_W      = 17;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        ACCUM      = 2'd1,
        EVAL       = 2'd2
    } state_t;

    // Vertical band index for an on-screen column (x_pos / REGION_W).
    function automatic logic [1:0] band_of(input logic [9:0] x);
        if (x < 10'(REGION_W))
            return 2'd0;
        else if (x < 10'(2 * REGION_W))
            return 2'd1;
        else if (x < 10'(3 * REGION_W))
            return 2'd2;
        else
            return 2'd3;
    endfunction

endpackage

// File: rtl/glove_region_detector_region_debounce.sv
// Per-band flag debouncer: a flag only changes after DEB_FRAMES consecutive
// evaluations disagree with it.
module region_debounce
    import glove_region_detector_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic eval,
    input  logic hit,
    output logic flag
);

    logic [DEB_W-1:0] deb_cnt;

    // Count disagreeing evaluations; toggle the flag when the run is long enough.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt <= '0;
            flag    <= 1'b0;
        end else if (eval) begin
            if (hit == flag) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_W'(DEB_FRAMES - 1)) begin
                flag    <= ~flag;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/glove_region_detector.sv
// Glove region detector: classifies pixels, counts glove pixels per vertical
// band, and once per frame publishes debounced red/green/blue/yellow flags.
module glove_region_detector
    import glove_region_detector_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              pixel_valid,
    input  logic [9:0]        x_pos,
    input  logic [9:0]        y_pos,
    input  logic [DATA_W-1:0] pix_r,
    input  logic [DATA_W-1:0] pix_g,
    input  logic [DATA_W-1:0] pix_b,
    output logic              red_flag,
    output logic              green_flag,
    output logic              blue_flag,
    output logic              yellow_flag,
    output logic              flags_valid
);

    // Colour test; differences are taken one bit wider and signed so a
    // component larger than red gives a negative result instead of wrapping.
    function automatic logic is_glove(input logic vld, input logic [9:0] x, input logic [9:0] y,
                                      input logic [DATA_W-1:0] r, input logic [DATA_W-1:0] g,
                                      input logic [DATA_W-1:0] b);
        logic signed [DATA_W:0] rg;
        logic signed [DATA_W:0] rb;
        rg = $signed({1'b0, r}) - $signed({1'b0, g});
        rb = $signed({1'b0, r}) - $signed({1'b0, b});
        return vld && (x < 10'(H_ACTIVE)) && (y < 10'(V_ACTIVE))
            && (r >= DATA_W'(R_MIN))
            && (rg >= $signed({1'b0, DATA_W'(RG_DIFF)}))
            && (rb >= $signed({1'b0, DATA_W'(RB_DIFF)}));
    endfunction

    // Saturating increment so an oversized band never wraps back below threshold.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t           state;
    logic [CNT_W-1:0] cnt    [NUM_BANDS];
    logic [CNT_W-1:0] snap_p1[NUM_BANDS];
    logic             glove_p0;
    logic [1:0]       band_p0;
    logic             eval_p1;
    logic [NUM_BANDS-1:0] hit_p1;
    logic [NUM_BANDS-1:0] band_flag;

    // ---- stage p0: per-pixel classification ----
    assign glove_p0 = is_glove(pixel_valid, x_pos, y_pos, pix_r, pix_g, pix_b);
    assign band_p0  = band_of(x_pos);

    // Frame sequencing, band accumulation and end-of-frame snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= WAIT_FRAME;
            flags_valid <= 1'b0;
            for (int b = 0; b < NUM_BANDS; b++) begin
                cnt[b]     <= '0;
                snap_p1[b] <= '0;
            end
        end else begin
            flags_valid <= (state == EVAL);
            case (state)
                WAIT_FRAME: begin
                    if (frame_start) begin
                        for (int b = 0; b < NUM_BANDS; b++)
                            cnt[b] <= '0;
                        state <= ACCUM;
                    end
                end
                ACCUM, EVAL: begin
                    if (frame_start) begin
                        // A glove pixel on the boundary cycle opens the new frame.
                        for (int b = 0; b < NUM_BANDS; b++) begin
                            snap_p1[b] <= cnt[b];
                            cnt[b]     <= (glove_p0 && band_p0 == 2'(b)) ? CNT_W'(1) : '0;
                        end
                        state <= EVAL;
                    end else begin
                        for (int b = 0; b < NUM_BANDS; b++)
                            if (glove_p0 && band_p0 == 2'(b))
                                cnt[b] <= sat_inc(cnt[b]);
                        state <= ACCUM;
                    end
                end
                default: state <= WAIT_FRAME;
            endcase
        end
    end

    // ---- stage p1: threshold the snapshot during the EVAL cycle ----
    assign eval_p1 = (state == EVAL);

    // Per-band hit decision from the frozen snapshot.
    always_comb begin
        hit_p1 = '0;
        for (int b = 0; b < NUM_BANDS; b++)
            hit_p1[b] = (snap_p1[b] >= CNT_W'(PIX_THRESH));
    end

    // ---- stage p2: debounced flags ----
    for (genvar gb = 0; gb < NUM_BANDS; gb++) begin : g_band
        region_debounce u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .eval  (eval_p1),
            .hit   (hit_p1[gb]),
            .flag  (band_flag[gb])
        );
    end

    assign red_flag    = band_flag[BAND_RED];
    assign green_flag  = band_flag[BAND_GREEN];
    assign blue_flag   = band_flag[BAND_BLUE];
    assign yellow_flag = band_flag[BAND_YELLOW];

endmodule

// File: tb/tb_glove_region_detector.sv
// Testbench for glove_region_detector: randomized pixel frames checked
// against a frame-level reference model of band counts and flag debouncing.
module tb_glove_region_detector;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       frame_start = 1'b0;
    logic       pixel_valid = 1'b0;
    logic [9:0] x_pos = '0;
    logic [9:0] y_pos = '0;
    logic [7:0] pix_r = '0;
    logic [7:0] pix_g = '0;
    logic [7:0] pix_b = '0;
    logic       red_flag, green_flag, blue_flag, yellow_flag, flags_valid;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state: glove counts of the frame in progress,
    // debounced flags and disagreement run lengths per band.
    bit   m_active;
    int   m_cnt [4];
    bit   m_flag[4];
    int   m_pend[4];
    int   due_q[$];
    logic [3:0] flags_q[$];
    logic [3:0] exp_flags = '0;
    logic       exp_fv = 1'b0;

    always #5 clk = ~clk;

    glove_region_detector dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .pixel_valid (pixel_valid),
        .x_pos       (x_pos),
        .y_pos       (y_pos),
        .pix_r       (pix_r),
        .pix_g       (pix_g),
        .pix_b       (pix_b),
        .red_flag    (red_flag),
        .green_flag  (green_flag),
        .blue_flag   (blue_flag),
        .yellow_flag (yellow_flag),
        .flags_valid (flags_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit is_glove(input bit v, input int x, input int y, input int r, input int g, input int b);
        return v && x < 640 && y < 480 && r >= 150 && (r - g) >= 60 && (r - b) >= 60;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endtask

    // End-of-frame evaluation; result becomes visible two edges after the pulse is sampled.
    task automatic model_eval();
        logic [3:0] f;
        bit hit;
        f = '0;
        for (int i = 0; i < 4; i++) begin
            hit = (m_cnt[i] >= 2000);
            if (hit == m_flag[i]) m_pend[i] = 0;
            else begin
                m_pend[i]++;
                if (m_pend[i] == 3) begin
                    m_flag[i] = !m_flag[i];
                    m_pend[i] = 0;
                end
            end
            f[i] = m_flag[i];
        end
        due_q.push_back(cyc + 2);
        flags_q.push_back(f);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        exp_fv = 1'b0;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            void'(due_q.pop_front());
            exp_flags = flags_q.pop_front();
            exp_fv = 1'b1;
        end
        check("flags_valid", flags_valid, exp_fv);
        check("flags_ybgr", {yellow_flag, blue_flag, green_flag, red_flag}, exp_flags);
    endtask

    task automatic idle(input int n);
        frame_start = 1'b0;
        pixel_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pix(input int x, input int y, input int r, input int g, input int b);
        frame_start = 1'b0;
        pixel_valid = 1'b1;
        x_pos = 10'(x); y_pos = 10'(y);
        pix_r = 8'(r); pix_g = 8'(g); pix_b = 8'(b);
        if (m_active && is_glove(1'b1, x, y, r, g, b)) m_cnt[x / 160]++;
        step();
        pixel_valid = 1'b0;
    endtask

    task automatic fs(input bit v, input int x, input int y, input int r, input int g, input int b);
        frame_start = 1'b1;
        pixel_valid = v;
        x_pos = 10'(x); y_pos = 10'(y);
        pix_r = 8'(r); pix_g = 8'(g); pix_b = 8'(b);
        if (!m_active) begin
            m_active = 1'b1;
            model_clear();
        end else begin
            model_eval();
            model_clear();
            if (is_glove(v, x, y, r, g, b)) m_cnt[x / 160] = 1;
        end
        step();
        frame_start = 1'b0;
        pixel_valid = 1'b0;
    endtask

    task automatic gpix(input int band);
        int r;
        r = int'($urandom_range(255, 150));
        pix(band * 160 + int'($urandom_range(159, 0)), int'($urandom_range(479, 0)),
            r, int'($urandom_range(r - 60, 0)), int'($urandom_range(r - 60, 0)));
    endtask

    // Near-miss colours and off-screen glove colours; none of these is a glove pixel.
    task automatic noise();
        int x, y;
        x = int'($urandom_range(639, 0));
        y = int'($urandom_range(479, 0));
        case ($urandom_range(5, 0))
            0: pix(x, y, 149, 0, 0);
            1: pix(x, y, 200, 141, 0);
            2: pix(x, y, 200, 0, 141);
            3: pix(x, y, 128, 128, 128);
            4: pix(640 + int'($urandom_range(383, 0)), y, 220, 10, 10);
            default: pix(x, 480 + int'($urandom_range(543, 0)), 220, 10, 10);
        endcase
    endtask

    task automatic glove_frame(input int band, input int n, input int extra);
        for (int i = 0; i < n; i++) gpix(band);
        for (int i = 0; i < extra; i++) begin
            gpix(int'($urandom_range(3, 0)));
            noise();
        end
        fs(1'b0, 0, 0, 0, 0, 0);
    endtask

    task automatic empty_frame();
        for (int i = 0; i < 20; i++) noise();
        fs(1'b0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        m_active = 1'b0;
        model_clear();
        for (int i = 0; i < 4; i++) begin m_flag[i] = 1'b0; m_pend[i] = 0; end

        // Power-on reset
        #2 rst_n = 1'b0;
        #1;
        check("reset_flags", {yellow_flag, blue_flag, green_flag, red_flag}, 4'd0);
        check("reset_valid", flags_valid, 1'b0);
        idle(3);
        rst_n = 1'b1;

        // Partial frame is ignored; grey frames give all-zero flags
        for (int i = 0; i < 40; i++) pix(int'($urandom_range(639, 0)), int'($urandom_range(479, 0)), 128, 128, 128);
        for (int i = 0; i < 30; i++) gpix(0);
        fs(1'b0, 0, 0, 0, 0, 0);
        idle(3);
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 300; i++) pix(int'($urandom_range(639, 0)), int'($urandom_range(479, 0)), 128, 128, 128);
            fs(1'b0, 0, 0, 0, 0, 0);
            idle(2);
        end

        // Fixed block x=10..209 of rows 0..9 straddling bands 0 and 1
        for (int f = 0; f < 3; f++) begin
            for (int y = 0; y < 10; y++)
                for (int x = 10; x < 210; x++) pix(x, y, 200, 50, 50);
            fs(1'b0, 0, 0, 0, 0, 0);
        end
        // Band 0 crosses threshold three frames running
        for (int f = 0; f < 3; f++) glove_frame(0, 2000, 10);
        idle(3);

        // Band 3 rises, then decays after three empty frames
        for (int f = 0; f < 3; f++) glove_frame(3, 2000, 10);
        idle(2);
        for (int f = 0; f < 3; f++) begin empty_frame(); idle(2); end

        // Band 1 rises, then back-to-back frame_start re-evaluates an empty snapshot
        for (int f = 0; f < 3; f++) glove_frame(1, 2010, 5);
        gpix(1);
        fs(1'b0, 0, 0, 0, 0, 0);
        fs(1'b0, 0, 0, 0, 0, 0);
        idle(3);
        for (int f = 0; f < 2; f++) begin empty_frame(); idle(2); end

        // Band 2 alternates hit / no-hit
        for (int f = 0; f < 3; f++) begin
            glove_frame(2, 2000, 5);
            empty_frame();
        end
        idle(3);

        // Glove pixel on the frame_start cycle belongs to the next frame
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 1999; i++) gpix(0);
            pix(640, 10, 200, 50, 50);
            pix(10, 480, 200, 50, 50);
            for (int i = 0; i < 10; i++) noise();
            fs(1'b1, int'($urandom_range(159, 0)), int'($urandom_range(479, 0)), 200, 50, 50);
        end
        fs(1'b0, 0, 0, 0, 0, 0);
        idle(3);

        // Reset in the middle of a frame with a flag raised
        for (int f = 0; f < 3; f++) glove_frame(0, 2000, 0);
        for (int i = 0; i < 5; i++) gpix(0);
        rst_n = 1'b0;
        #1;
        check("midreset_flags", {yellow_flag, blue_flag, green_flag, red_flag}, 4'd0);
        check("midreset_valid", flags_valid, 1'b0);
        m_active = 1'b0;
        model_clear();
        for (int i = 0; i < 4; i++) begin m_flag[i] = 1'b0; m_pend[i] = 0; end
        due_q.delete();
        flags_q.delete();
        exp_flags = '0;
        idle(3);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) gpix(0);
        fs(1'b0, 0, 0, 0, 0, 0);
        idle(2);
        glove_frame(0, 2000, 0);
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
